// File: rtl/func_slot_pkg.sv
// Shared types and defaults for the function-slot enable scheduler.
// Index widths come from idx_w so every counter is sized from its own limit.
package func_slot_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_GUARD} state_t;

  localparam int SYSCLK_HZ      = 50000000;
  localparam int DEF_N_SLOTS    = 4;
  localparam int DEF_AUTO_TICKS = SYSCLK_HZ;
  localparam int DEF_GUARD_CYC  = 4;
  localparam int DEF_DRAIN_MAX  = 1024;

  // Bits needed to hold values 0..n-1 (at least one bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/func_slot_scheduler_auto_tick_timer.sv
// Auto-advance interval counter: counts while enabled, emits a one-cycle tick
// on its last count and reloads; clr restarts the interval.
module auto_tick_timer
  import func_slot_pkg::*;
#(
  parameter int AUTO_TICKS = DEF_AUTO_TICKS
) (
  input  logic sysclk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = idx_w(AUTO_TICKS);
  localparam logic [CW-1:0] LAST = CW'(AUTO_TICKS - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en & (cnt_reg == LAST);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/func_slot_scheduler.sv
// Sole owner of the one-hot function-slot enable bus; every slot change is a
// make-after-break handover (drop enable, drain old slot, guard gap, enable new).
module func_slot_scheduler
  import func_slot_pkg::*;
#(
  parameter int N_SLOTS    = DEF_N_SLOTS,
  parameter int AUTO_TICKS = DEF_AUTO_TICKS,
  parameter int GUARD_CYC  = DEF_GUARD_CYC,
  parameter int DRAIN_MAX  = DEF_DRAIN_MAX
) (
  input  logic                        sysclk,
  input  logic                        reset,
  input  logic                        next_pulse,
  input  logic                        pre_pulse,
  input  logic                        auto_pulse,
  input  logic [N_SLOTS-1:0]          slot_idle,
  output logic [N_SLOTS-1:0]          enable_sw,
  output logic [idx_w(N_SLOTS)-1:0]   cur_slot,
  output logic                        auto_mode,
  output logic                        busy,
  output logic                        drain_timeout
);

  localparam int SW = idx_w(N_SLOTS);
  localparam int DW = idx_w(DRAIN_MAX);
  localparam int GW = idx_w(GUARD_CYC);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(N_SLOTS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);

  state_t               state_reg, state_next;
  logic [SW-1:0]        cur_slot_reg, cur_slot_next;
  logic [SW-1:0]        old_slot_reg, old_slot_next;
  logic [N_SLOTS-1:0]   enable_reg, enable_next;
  logic                 auto_mode_reg, auto_mode_next;
  logic                 busy_reg, busy_next;
  logic                 timeout_reg, timeout_next;
  logic [DW-1:0]        drain_cnt_reg, drain_cnt_next;
  logic [GW-1:0]        guard_cnt_reg, guard_cnt_next;

  logic          in_run, step_up, step_dn, manual_step;
  logic          auto_tick, timer_en, timer_clr;
  logic [SW-1:0] slot_inc, slot_dec;

  assign in_run   = (state_reg == ST_RUN);
  assign slot_inc = (cur_slot_reg == LAST_SLOT) ? '0 : cur_slot_reg + SW'(1);
  assign slot_dec = (cur_slot_reg == '0) ? LAST_SLOT : cur_slot_reg - SW'(1);

  // Both manual buttons together cancel everything, including an auto tick;
  // a single manual button overrides the auto direction.
  assign step_up     = in_run & ~(next_pulse & pre_pulse) & (next_pulse | (auto_tick & ~pre_pulse));
  assign step_dn     = in_run & pre_pulse & ~next_pulse;
  assign manual_step = in_run & (next_pulse ^ pre_pulse);

  assign timer_en  = in_run & auto_mode_reg;
  assign timer_clr = auto_pulse | manual_step | ~in_run;

  auto_tick_timer #(
    .AUTO_TICKS(AUTO_TICKS)
  ) u_auto_tick_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .en     (timer_en),
    .clr    (timer_clr),
    .tick   (auto_tick)
  );

  always_comb begin
    state_next     = state_reg;
    cur_slot_next  = cur_slot_reg;
    old_slot_next  = old_slot_reg;
    enable_next    = enable_reg;
    busy_next      = busy_reg;
    drain_cnt_next = drain_cnt_reg;
    guard_cnt_next = guard_cnt_reg;
    timeout_next   = 1'b0;
    auto_mode_next = auto_mode_reg ^ auto_pulse;

    case (state_reg)
      ST_RUN: begin
        if (step_up | step_dn) begin
          state_next     = ST_DRAIN;
          enable_next    = '0;
          busy_next      = 1'b1;
          old_slot_next  = cur_slot_reg;
          cur_slot_next  = step_up ? slot_inc : slot_dec;
          drain_cnt_next = '0;
        end
      end
      ST_DRAIN: begin
        if (slot_idle[old_slot_reg]) begin
          state_next     = ST_GUARD;
          guard_cnt_next = '0;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          // Outgoing slot never quiesced: hand over anyway and flag it.
          state_next     = ST_GUARD;
          guard_cnt_next = '0;
          timeout_next   = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt_reg + DW'(1);
        end
      end
      ST_GUARD: begin
        if (guard_cnt_reg == GUARD_LAST) begin
          state_next                = ST_RUN;
          busy_next                 = 1'b0;
          enable_next               = '0;
          enable_next[cur_slot_reg] = 1'b1;
        end else begin
          guard_cnt_next = guard_cnt_reg + GW'(1);
        end
      end
      default: begin
        state_next    = ST_RUN;
        busy_next     = 1'b0;
        cur_slot_next = '0;
        enable_next   = N_SLOTS'(1);
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      cur_slot_reg  <= '0;
      old_slot_reg  <= '0;
      enable_reg    <= N_SLOTS'(1);
      auto_mode_reg <= 1'b0;
      busy_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
      drain_cnt_reg <= '0;
      guard_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cur_slot_reg  <= cur_slot_next;
      old_slot_reg  <= old_slot_next;
      enable_reg    <= enable_next;
      auto_mode_reg <= auto_mode_next;
      busy_reg      <= busy_next;
      timeout_reg   <= timeout_next;
      drain_cnt_reg <= drain_cnt_next;
      guard_cnt_reg <= guard_cnt_next;
    end
  end

  assign enable_sw     = enable_reg;
  assign cur_slot      = cur_slot_reg;
  assign auto_mode     = auto_mode_reg;
  assign busy          = busy_reg;
  assign drain_timeout = timeout_reg;

endmodule

// File: tb/tb_func_slot_scheduler.sv
// Directed bench for func_slot_scheduler: handover timing, wrap, drain timeout,
// auto advance, cancel/drop rules and asynchronous reset mid-handover.
module tb_func_slot_scheduler;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       next_pulse, pre_pulse, auto_pulse;
  logic [3:0] slot_idle;
  logic [3:0] enable_sw;
  logic [1:0] cur_slot;
  logic       auto_mode, busy, drain_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  func_slot_scheduler #(
    .N_SLOTS(4), .AUTO_TICKS(10), .GUARD_CYC(4), .DRAIN_MAX(16)
  ) dut (
    .sysclk(sysclk), .reset(reset),
    .next_pulse(next_pulse), .pre_pulse(pre_pulse), .auto_pulse(auto_pulse),
    .slot_idle(slot_idle), .enable_sw(enable_sw), .cur_slot(cur_slot),
    .auto_mode(auto_mode), .busy(busy), .drain_timeout(drain_timeout)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic pulse(input logic nxt, input logic pre, input logic aut);
    next_pulse = nxt; pre_pulse = pre; auto_pulse = aut;
    tick();
    next_pulse = 1'b0; pre_pulse = 1'b0; auto_pulse = 1'b0;
  endtask

  // Called one cycle after the request; returns the offset of the first RUN cycle.
  task automatic watch_handover(input int raise_at, output int tcnt, output int tpos,
                                output int run_at, output int bad);
    int off;
    off = 1; tcnt = 0; tpos = 0; bad = 0;
    while (busy && off < 64) begin
      if (drain_timeout) begin tcnt++; tpos = off; end
      if (enable_sw != 4'b0000) bad++;
      if (off == raise_at) slot_idle = 4'b1111;
      tick();
      off++;
    end
    run_at = off;
  endtask

  task automatic do_step(input logic nxt, input logic pre, input logic [3:0] exp_en,
                         input logic [1:0] exp_cur, input string tag);
    int tcnt, tpos, run_at, bad;
    pulse(nxt, pre, 1'b0);
    chk({tag, "_busy_t1"}, busy, 1);
    chk({tag, "_cur_t1"}, cur_slot, exp_cur);
    watch_handover(0, tcnt, tpos, run_at, bad);
    chk({tag, "_run_at"}, run_at, 6);
    chk({tag, "_zero_en"}, bad, 0);
    chk({tag, "_no_to"}, tcnt, 0);
    chk({tag, "_en"}, enable_sw, exp_en);
    chk({tag, "_cur"}, cur_slot, exp_cur);
  endtask

  initial begin
    int tcnt, tpos, run_at, bad, ns, nr, nb;
    int starts[4];
    int runs[4];
    logic [3:0] ens[4];
    logic prev_busy;

    reset = 1'b1; next_pulse = 1'b0; pre_pulse = 1'b0; auto_pulse = 1'b0;
    slot_idle = 4'b1111;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_en", enable_sw, 4'b0001);
    chk("rst_cur", cur_slot, 0);
    chk("rst_auto", auto_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_to", drain_timeout, 0);

    // Basic next: enable 0 over t+1..t+5, 0010 at t+6.
    do_step(1, 0, 4'b0010, 2'd1, "next0");
    $display("[TB] next 0->1 en=%b cur=%0d", enable_sw, cur_slot);
    do_step(0, 1, 4'b0001, 2'd0, "pre1");
    do_step(0, 1, 4'b1000, 2'd3, "pre_wrap");
    $display("[TB] pre wrap 0->3 en=%b", enable_sw);
    do_step(1, 0, 4'b0001, 2'd0, "next_wrap");
    do_step(1, 0, 4'b0010, 2'd1, "lap1");
    do_step(1, 0, 4'b0100, 2'd2, "lap2");
    do_step(1, 0, 4'b1000, 2'd3, "lap3");
    do_step(1, 0, 4'b0001, 2'd0, "lap4");
    $display("[TB] four nexts from 0 en=%b", enable_sw);

    // Drain timeout: old slot 0 never idle, DRAIN_MAX=16.
    slot_idle = 4'b1110;
    pulse(1, 0, 0);
    watch_handover(0, tcnt, tpos, run_at, bad);
    slot_idle = 4'b1111;
    chk("to_count", tcnt, 1);
    chk("to_pos", tpos, 17);
    chk("to_run_at", run_at, 21);
    chk("to_en", enable_sw, 4'b0010);
    chk("to_zero_en", bad, 0);
    $display("[TB] drain timeout pulses=%0d at %0d, run at %0d", tcnt, tpos, run_at);

    // Idle raised during cycle t+5: GUARD at t+6, RUN at t+10.
    do_step(0, 1, 4'b0001, 2'd0, "back0");
    slot_idle = 4'b1110;
    pulse(1, 0, 0);
    watch_handover(5, tcnt, tpos, run_at, bad);
    chk("late_idle_to", tcnt, 0);
    chk("late_idle_run_at", run_at, 10);
    chk("late_idle_en", enable_sw, 4'b0010);
    $display("[TB] late idle run at %0d timeouts=%0d", run_at, tcnt);

    // Auto mode from slot 0.
    do_step(0, 1, 4'b0001, 2'd0, "back0b");
    pulse(0, 0, 1);
    chk("auto_on", auto_mode, 1);
    ns = 0; nr = 0; prev_busy = 1'b0;
    for (int off = 1; off <= 62; off++) begin
      if (busy && !prev_busy && ns < 4) begin starts[ns] = off; ns++; end
      if (!busy && prev_busy && nr < 4) begin runs[nr] = off; ens[nr] = enable_sw; nr++; end
      prev_busy = busy;
      if (off < 62) tick();
    end
    chk("auto_nstarts", ns, 4);
    chk("auto_nruns", nr, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("auto_start%0d", i), (i < ns) ? starts[i] : -1, 11 + 15 * i);
      chk($sformatf("auto_run%0d", i), (i < nr) ? runs[i] : -1, 16 + 15 * i);
      $display("[TB] auto step %0d start=%0d run=%0d en=%b", i, starts[i], runs[i], ens[i]);
    end
    chk("auto_en0", ens[0], 4'b0010);
    chk("auto_en1", ens[1], 4'b0100);
    chk("auto_en2", ens[2], 4'b1000);
    chk("auto_en3", ens[3], 4'b0001);
    pulse(0, 0, 1);
    chk("auto_off", auto_mode, 0);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) nb++;
      tick();
    end
    chk("auto_off_nobusy", nb, 0);
    chk("auto_off_en", enable_sw, 4'b0001);

    // Next and pre together: no step.
    pulse(1, 1, 0);
    chk("cancel_busy", busy, 0);
    chk("cancel_cur", cur_slot, 0);
    repeat (3) tick();
    chk("cancel_en", enable_sw, 4'b0001);
    $display("[TB] cancel en=%b busy=%0d", enable_sw, busy);

    // Next while busy is dropped.
    pulse(1, 0, 0);
    tick();
    pulse(1, 0, 0);
    watch_handover(0, tcnt, tpos, run_at, bad);
    chk("drop_en", enable_sw, 4'b0010);
    chk("drop_cur", cur_slot, 1);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy) nb++;
      tick();
    end
    chk("drop_noqueue", nb, 0);
    $display("[TB] drop while busy en=%b cur=%0d", enable_sw, cur_slot);

    // Asynchronous reset during GUARD (offset 3).
    pulse(1, 0, 1);
    chk("rg_cur", cur_slot, 2);
    chk("rg_auto", auto_mode, 1);
    tick();
    tick();
    chk("rg_busy", busy, 1);
    chk("rg_en0", enable_sw, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_en", enable_sw, 4'b0001);
    chk("arst_cur", cur_slot, 0);
    chk("arst_auto", auto_mode, 0);
    chk("arst_busy", busy, 0);
    $display("[TB] async reset en=%b cur=%0d auto=%0d", enable_sw, cur_slot, auto_mode);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_en", enable_sw, 4'b0001);
    chk("post_rst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
